mac32_result_collector: RTL and testbench

MAC32_RESULT_COLLECTOR -- requirements
Module: mac32_result_collector

---
 rtl/mac32_result_collector.sv | 138 +++++++++++++
 tb/tb_mac32_result_collector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac32_result_collector.sv
// Collects results from a fixed-latency MAC into an in-order FIFO, with
// credit-based issue flow control, sticky FP flags and an overflow error.
module mac32_result_collector #(
  parameter int DEPTH = 4,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [TAG_W-1:0] issue_tag_i,
  input  logic [1:0]       issue_mode_i,
  input  logic [31:0]      mac_result_i,
  input  logic [3:0]       mac_flags_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [1:0]       out_mode_o,
  output logic [3:0]       out_flags_o,
  output logic [3:0]       fflags_o,
  input  logic             fflags_clr_i,
  output logic             err_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 + TAG_W + 2 + 4;

  logic [CW-1:0]    credit;
  logic [LAT-1:0]   pipe_v;
  logic [TAG_W-1:0] pipe_tag  [LAT];
  logic [1:0]       pipe_mode [LAT];

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic             issue_acc;
  logic             pop;
  logic             cap;
  logic             full;
  logic             push;
  logic             overflow;
  logic [31:0]      cap_result;
  logic [EW-1:0]    head;

  assign issue_ready_o = (credit != '0);
  assign issue_acc     = issue_valid_i & issue_ready_o;
  assign out_valid_o   = (count_q != '0);
  assign pop           = out_valid_o & out_ready_i;
  assign cap           = pipe_v[LAT-1];
  assign full          = (count_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot the capture needs.
  assign push          = cap & (~full | pop);
  assign overflow      = cap & full & ~pop;
  assign cap_result    = (pipe_mode[LAT-1] == 2'b01) ? {16'h0000, mac_result_i[15:0]}
                                                     : mac_result_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CW'(DEPTH);
    end else begin
      case ({issue_acc, pop})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_tag[i]  <= '0;
        pipe_mode[i] <= '0;
      end
    end else begin
      pipe_v[0]    <= issue_acc;
      pipe_tag[0]  <= issue_tag_i;
      pipe_mode[0] <= issue_mode_i;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_mode[i] <= pipe_mode[i-1];
      end
    end
  end

  // Storage is not reset; outputs are gated by out_valid_o instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cap_result, pipe_tag[LAT-1], pipe_mode[LAT-1], mac_flags_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_o <= '0;
      err_o    <= 1'b0;
    end else begin
      if (push) begin
        fflags_o <= fflags_clr_i ? mac_flags_i : (fflags_o | mac_flags_i);
      end else if (fflags_clr_i) begin
        fflags_o <= '0;
      end
      if (overflow) err_o <= 1'b1;
    end
  end

  assign head         = out_valid_o ? mem[rd_ptr] : '0;
  assign out_result_o = head[EW-1 -: 32];
  assign out_tag_o    = head[TAG_W+5 -: TAG_W];
  assign out_mode_o   = head[5:4];
  assign out_flags_o  = head[3:0];
  assign count_o      = count_q;

endmodule

// File: tb/tb_mac32_result_collector.sv
// Randomized and directed bench for mac32_result_collector against a
// queue-based model of in-flight operations and FIFO contents.
module tb_mac32_result_collector;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid_i = 1'b0;
  logic             issue_ready_o;
  logic [TAG_W-1:0] issue_tag_i = '0;
  logic [1:0]       issue_mode_i = '0;
  logic [31:0]      mac_result_i = '0;
  logic [3:0]       mac_flags_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [31:0]      out_result_o;
  logic [TAG_W-1:0] out_tag_o;
  logic [1:0]       out_mode_o;
  logic [3:0]       out_flags_o;
  logic [3:0]       fflags_o;
  logic             fflags_clr_i = 1'b0;
  logic             err_o;
  logic [$clog2(DEPTH):0] count_o;

  mac32_result_collector #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_tag_i(issue_tag_i), .issue_mode_i(issue_mode_i),
    .mac_result_i(mac_result_i), .mac_flags_i(mac_flags_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_tag_o(out_tag_o),
    .out_mode_o(out_mode_o), .out_flags_o(out_flags_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .err_o(err_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] r; logic [TAG_W-1:0] tag; logic [1:0] mode; logic [3:0] fl; } ent_t;
  typedef struct { int due; logic [TAG_W-1:0] tag; logic [1:0] mode; } inf_t;

  ent_t fq[$];
  inf_t iq[$];
  logic [3:0] m_ff = '0;
  logic m_err = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Models what one rising edge does given the inputs about to be applied.
  task automatic model_step(input logic iv, input logic [TAG_W-1:0] tg, input logic [1:0] md,
                            input logic [31:0] res, input logic [3:0] fl, input logic ordy,
                            input logic clr);
    bit acc, pop, cap, full;
    inf_t f;
    ent_t e;
    acc  = iv && ((DEPTH - iq.size() - fq.size()) != 0);
    pop  = (fq.size() != 0) && ordy;
    cap  = (iq.size() != 0) && (iq[0].due == cyc);
    full = (fq.size() == DEPTH);
    if (pop) void'(fq.pop_front());
    if (cap) begin
      f = iq.pop_front();
      if (full && !pop) begin
        m_err = 1'b1;
        if (clr) m_ff = '0;
      end else begin
        e.r    = (f.mode == 2'b01) ? (res & 32'h0000_FFFF) : res;
        e.tag  = f.tag;
        e.mode = f.mode;
        e.fl   = fl;
        fq.push_back(e);
        m_ff = clr ? fl : (m_ff | fl);
      end
    end else if (clr) begin
      m_ff = '0;
    end
    if (acc) begin
      f.due = cyc + LAT; f.tag = tg; f.mode = md;
      iq.push_back(f);
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("issue_ready", 32'(issue_ready_o), 32'((DEPTH - iq.size() - fq.size()) != 0));
    chk("count", 32'(count_o), 32'(fq.size()));
    chk("out_valid", 32'(out_valid_o), 32'(fq.size() != 0));
    chk("fflags", 32'(fflags_o), 32'(m_ff));
    chk("err", 32'(err_o), 32'(m_err));
    if (fq.size() != 0) begin
      chk("out_result", out_result_o, fq[0].r);
      chk("out_tag", 32'(out_tag_o), 32'(fq[0].tag));
      chk("out_mode", 32'(out_mode_o), 32'(fq[0].mode));
      chk("out_flags", 32'(out_flags_o), 32'(fq[0].fl));
    end
  endtask

  task automatic cycle(input logic iv, input logic [TAG_W-1:0] tg, input logic [1:0] md,
                       input logic [31:0] res, input logic [3:0] fl, input logic ordy,
                       input logic clr);
    issue_valid_i = iv; issue_tag_i = tg; issue_mode_i = md;
    mac_result_i = res; mac_flags_i = fl; out_ready_i = ordy; fflags_clr_i = clr;
    model_step(iv, tg, md, res, fl, ordy, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + LAT + 1; i++) cycle(1'b0, '0, 2'b00, $urandom, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    int acc_cnt;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_result", out_result_o, 32'd0);
    rst_n = 1'b1;

    // Single FP32 op
    cycle(1'b1, 4'd3, 2'b00, $urandom, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 2'b00, $urandom, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 2'b00, 32'h3F80_0000, 4'b0001, 1'b0, 1'b0);
    chk("single_valid", 32'(out_valid_o), 32'd1);
    chk("single_result", out_result_o, 32'h3F80_0000);
    chk("single_tag", 32'(out_tag_o), 32'd3);
    chk("single_fflags", 32'(fflags_o), 32'b0001);
    cycle(1'b0, 4'd0, 2'b00, $urandom, 4'h0, 1'b1, 1'b0);

    // FP16 masking, flags accumulate to 0011
    cycle(1'b1, 4'd5, 2'b01, $urandom, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 2'b00, $urandom, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 2'b00, 32'hABCD_3C00, 4'b0010, 1'b0, 1'b0);
    chk("fp16_result", out_result_o, 32'h0000_3C00);
    chk("fp16_fflags", 32'(fflags_o), 32'b0011);
    cycle(1'b0, 4'd0, 2'b00, $urandom, 4'h0, 1'b1, 1'b0);

    // Clear coinciding with push, then clear alone
    cycle(1'b1, 4'd7, 2'b00, $urandom, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 2'b00, $urandom, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 2'b00, 32'h1234_5678, 4'b1000, 1'b0, 1'b1);
    chk("clr_push_fflags", 32'(fflags_o), 32'b1000);
    cycle(1'b0, 4'd0, 2'b00, $urandom, 4'h0, 1'b1, 1'b1);
    chk("clr_alone_fflags", 32'(fflags_o), 32'b0000);
    drain();

    // Backpressure: issue held high, downstream stalled
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (issue_ready_o) acc_cnt++;
      cycle(1'b1, TAG_W'(i), 2'b00, $urandom, 4'h0, 1'b0, 1'b0);
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd4);
    chk("bp_ready_low", 32'(issue_ready_o), 32'd0);
    chk("bp_count", 32'(count_o), 32'd4);
    chk("bp_head_tag0", 32'(out_tag_o), 32'd0);
    cycle(1'b1, 4'd9, 2'b00, $urandom, 4'h0, 1'b1, 1'b0);
    chk("bp_ready_after_pop", 32'(issue_ready_o), 32'd1);
    for (int t = 1; t < 4; t++) begin
      chk("bp_order", 32'(out_tag_o), 32'(t));
      cycle(1'b0, 4'd0, 2'b00, $urandom, 4'h0, 1'b1, 1'b0);
    end
    drain();

    // Streaming: issue, push and pop every cycle, steady occupancy of 1
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, TAG_W'($urandom), 2'($urandom_range(0, 2)), $urandom, 4'($urandom), 1'b1, 1'b0);
      if (i >= 4) begin
        chk("stream_count", 32'(count_o), 32'd1);
        chk("stream_ready", 32'(issue_ready_o), 32'd1);
      end
    end
    chk("stream_err", 32'(err_o), 32'd0);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), TAG_W'($urandom), 2'($urandom_range(0, 2)), $urandom,
            4'($urandom), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0));
    end
    drain();

    // Reset with 2 queued and 2 in flight
    for (int i = 0; i < 4; i++) cycle(1'b1, TAG_W'(i + 8), 2'b00, $urandom, 4'hF, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd2);
    #2 rst_n = 1'b0;
    issue_valid_i = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid_o), 32'd0);
    chk("rst_mid_count", 32'(count_o), 32'd0);
    chk("rst_mid_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_mid_fflags", 32'(fflags_o), 32'd0);
    chk("rst_mid_result", out_result_o, 32'd0);
    fq.delete(); iq.delete(); m_ff = '0; m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * LAT + 2; i++) begin
      cycle(1'b0, 4'd0, 2'b00, $urandom, 4'hF, 1'b0, 1'b0);
      chk("post_rst_no_output", 32'(out_valid_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
